// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for the sequential divider.
// Master is the controlling datapath, slave is the divide unit.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Trial subtract is a full-adder ripple: a + ~b + 1.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   sub_a;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH-1:0] sub_t;
  logic [WIDTH+1:0] cy;
  logic             no_borrow;

  always_comb begin
    sub_a = {r_q, q_q[WIDTH-1]};
    sub_b = ~{1'b0, d_q};
    sub_t = '0;
    cy    = '0;
    cy[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      sub_t[i] = sub_a[i] ^ sub_b[i] ^ cy[i];
      cy[i+1]  = (sub_a[i] & sub_b[i])
               | (cy[i] & (sub_a[i] ^ sub_b[i]));
    end
    cy[WIDTH+1] = (sub_a[WIDTH] & sub_b[WIDTH])
                | (cy[WIDTH] & (sub_a[WIDTH] ^ sub_b[WIDTH]));
    no_borrow = cy[WIDTH+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    d_d   = d_q;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          d_d   = bus.divisor;
          q_d   = bus.dividend;
          r_d   = '0;
          cnt_d = CW'(WIDTH);
          dbz_d = (bus.divisor == '0);
          if (bus.divisor == '0) begin
            quo_d = '1;
            rem_d = bus.dividend;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - CW'(1);
        // On borrow the shifted partial remainder is kept as-is
        if (no_borrow) begin
          r_d = sub_t;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = sub_a[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CW'(1)) begin
          quo_d = q_d;
          rem_d = r_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      d_q   <= d_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end

  always_comb begin
    bus.busy        = (state_q != IDLE);
    bus.done        = (state_q == DONE);
    bus.quotient    = quo_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider.
// WIDTH=8 main instance plus a WIDTH=16 instance.
module tb_seq_divider;

  logic clk;
  logic rst_n;

  int vecs;
  int errs;

  seq_divider_if #(.WIDTH(8))  b8();
  seq_divider_if #(.WIDTH(16)) b16();

  seq_divider #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    b8.start    = 1'b1;
    b8.dividend = a;
    b8.divisor  = b;
    @(posedge clk);
    #1;
    b8.start    = 1'b0;
    b8.dividend = ~a;
    b8.divisor  = ~b;
  endtask

  // n = rising edges after the accepting edge when done is seen
  task automatic wait8(input int poke, output int n, output bit got);
    got = 1'b0;
    for (n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (n == poke) begin
        b8.start    = 1'b1;
        b8.dividend = 8'd50;
        b8.divisor  = 8'd5;
      end else begin
        b8.start = 1'b0;
      end
      if (b8.done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
    end
    b8.start = 1'b0;
    chk("done_timeout", 32'(got), 32'd1);
  endtask

  task automatic run8(input vec_t v, input string nm);
    int  n;
    bit  got;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    launch8(v.a, v.b);
    chk({nm, "_busy_at_accept"}, 32'(b8.busy), 32'd1);
    wait8(-5, n, got);
    q = b8.quotient;
    r = b8.remainder;
    z = b8.div_by_zero;
    chk({nm, "_q"}, 32'(q), 32'(v.q));
    chk({nm, "_r"}, 32'(r), 32'(v.r));
    chk({nm, "_dbz"}, 32'(z), 32'(v.z));
    chk({nm, "_lat"}, 32'(n), v.z ? 32'd0 : 32'd8);
    @(negedge clk);
    chk({nm, "_done_width"}, 32'(b8.done), 32'd0);
    chk({nm, "_busy_end"}, 32'(b8.busy), 32'd0);
    chk({nm, "_q_hold"}, 32'(b8.quotient), 32'(v.q));
  endtask

  vec_t tbl[12];

  initial begin
    int  n;
    int  cnt;
    bit  got;
    vec_t v;
    vecs = 0;
    errs = 0;

    tbl[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    tbl[1]  = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    tbl[2]  = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    tbl[3]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    tbl[4]  = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0};
    tbl[5]  = '{8'd77,  8'd0,   8'd255, 8'd77, 1'b1};
    tbl[6]  = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0};
    tbl[7]  = '{8'd1,   8'd2,   8'd0,   8'd1,  1'b0};
    tbl[8]  = '{8'd254, 8'd16,  8'd15,  8'd14, 1'b0};
    tbl[9]  = '{8'd128, 8'd128, 8'd1,   8'd0,  1'b0};
    tbl[10] = '{8'd0,   8'd0,   8'd255, 8'd0,  1'b1};
    tbl[11] = '{8'd200, 8'd201, 8'd0,   8'd200, 1'b0};

    rst_n        = 1'b0;
    b8.start     = 1'b0;
    b8.dividend  = '0;
    b8.divisor   = '0;
    b16.start    = 1'b0;
    b16.dividend = '0;
    b16.divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(b8.busy), 32'd0);
    chk("rst_done", 32'(b8.done), 32'd0);
    chk("rst_q", 32'(b8.quotient), 32'd0);
    chk("rst_r", 32'(b8.remainder), 32'd0);
    chk("rst_dbz", 32'(b8.div_by_zero), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run8(tbl[i], $sformatf("tbl%0d", i));
    end

    // start while busy must not disturb 200/13
    launch8(8'd200, 8'd13);
    wait8(3, n, got);
    chk("busy_start_q", 32'(b8.quotient), 32'd15);
    chk("busy_start_r", 32'(b8.remainder), 32'd5);
    chk("busy_start_lat", 32'(n), 32'd8);
    cnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (b8.done) cnt++;
    end
    chk("busy_start_no_2nd_done", 32'(cnt), 32'd0);

    // asynchronous reset mid-operation
    launch8(8'd150, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(b8.busy), 32'd0);
    chk("midrst_done", 32'(b8.done), 32'd0);
    chk("midrst_q", 32'(b8.quotient), 32'd0);
    chk("midrst_r", 32'(b8.remainder), 32'd0);
    chk("midrst_dbz", 32'(b8.div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (b8.done) cnt++;
    end
    chk("midrst_no_done", 32'(cnt), 32'd0);
    run8('{8'd60, 8'd4, 8'd15, 8'd0, 1'b0}, "after_rst");

    for (int i = 0; i < 400; i++) begin
      v.a = 8'($urandom);
      v.b = (i % 37 == 0) ? 8'd0 : 8'($urandom);
      if (v.b == 0) begin
        v.q = 8'hFF;
        v.r = v.a;
        v.z = 1'b1;
      end else begin
        v.q = v.a / v.b;
        v.r = v.a % v.b;
        v.z = 1'b0;
      end
      run8(v, "rnd8");
    end

    for (int i = 0; i < 150; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = (i % 4 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom);
      if (b == 0) b = 16'd1;
      @(negedge clk);
      b16.start    = 1'b1;
      b16.dividend = a;
      b16.divisor  = b;
      @(posedge clk);
      #1;
      b16.start = 1'b0;
      got = 1'b0;
      for (n = 0; n <= 40; n++) begin
        @(negedge clk);
        if (b16.done) begin
          got = 1'b1;
          break;
        end
        @(posedge clk);
      end
      chk("rnd16_timeout", 32'(got), 32'd1);
      chk("rnd16_q", 32'(b16.quotient), 32'(a / b));
      chk("rnd16_r", 32'(b16.remainder), 32'(a % b));
      chk("rnd16_lat", 32'(n), 32'd16);
      @(negedge clk);
      chk("rnd16_done_width", 32'(b16.done), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
